mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one unified single-port memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipeline. It registers the grant, drives the memory port through a req/ack handshake, returns read data to the winner, and raises per-stage stall signals for the hazard unit. Data has priority over fetch, with a starvation guard for fetch, and a watchdog flags a hung memory.

Parameters:
MAX_D_STREAK, 4, consecutive data grants allowed while ireq is pending before fetch is forced to win
TIMEOUT, 255, BUSY cycles without mack before abort (8-bit counter; legal range 1..255)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
ireq  in  1  fetch request; held high until iready
iaddr  in  32  fetch word address
irdata  out  32  fetch data; valid only when iready=1
iready  out  1  one-cycle fetch completion pulse
dreq  in  1  data request; held high until dready
dwe  in  1  1 = store, 0 = load
dbe  in  4  store byte enables
daddr  in  32  data address
dwdata  in  32  store data
drdata  out  32  load data; valid only when dready=1
dready  out  1  one-cycle data completion pulse
mreq  out  1  memory request
mwe  out  1  memory write enable
mbe  out  4  memory byte enables (4'b1111 for fetch)
maddr  out  32  memory address
mwdata  out  32  memory write data
mrdata  in  32  memory read data; valid with mack
mack  in  1  memory completion, only meaningful while mreq=1
stall_if  out  1  ireq & ~iready
stall_mem  out  1  dreq & ~dready
err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. On reset=0 (any state, including mid-access): state=IDLE, mreq=0, mwe=0, mbe=0, maddr=0, mwdata=0, err=0, streak=0, timer=0. iready, dready, irdata and drdata are 0 during reset. Any access in flight is dropped with no ready pulse.
- IDLE: arbitrate on the current ireq/dreq and latch the winner's address, we, be and wdata into the m* registers. mreq=1 from the next cycle.
  - dreq only -> BUSY_D.
  - ireq only -> BUSY_I.
  - Both -> BUSY_D, unless streak==MAX_D_STREAK, in which case BUSY_I.
  - Neither -> stay IDLE, mreq=0.
- streak: increments on each data grant made while ireq=1. Clears on any fetch grant, or on a data grant made while ireq=0. Saturates at MAX_D_STREAK.
- BUSY_x: m* outputs held stable and mreq=1. mack may arrive in the first BUSY cycle or any later one. In the mack cycle:
  - iready (BUSY_I) or dready (BUSY_D) =1, combinationally.
  - irdata/drdata = mrdata. For stores, drdata=0.
  - Next state IDLE with mreq=0.
  - Minimum 2 cycles per access; one IDLE bubble between accesses.
- The requester must hold req and all its inputs stable until ready. Changes made while that requester is granted are ignored. The requester samples ready at the clock edge and may drop or reissue req on the following cycle. A req still high in the cycle after ready counts as a new request.
- Watchdog: timer clears on entry to BUSY and increments each BUSY cycle without mack. If timer==TIMEOUT-1 with no mack:
  - err=1 (sticky until reset).
  - The granted ready pulses that cycle with data 32'hDEADBEEF.
  - mreq drops and state returns to IDLE.
  - mack arriving in that same cycle wins, giving a normal completion with no err.
- mack while mreq=0 is ignored.
- No combinational path from mack/mrdata to m* outputs. Ready and data paths are combinational by design.

Test Plan:
- Single fetch: ireq=1, iaddr=0x00003000, mack one cycle after mreq, mrdata=0x24080005 -> maddr=0x3000, mbe=4'hF, mwe=0. iready pulses on cycle 3 after ireq with irdata=0x24080005. stall_if=1 on cycles 1-2.
- Store: dreq=1, dwe=1, dbe=4'b0011, daddr=0x10, dwdata=0xAABBCCDD, mack after 3 cycles -> mwe=1, mbe=4'b0011, mwdata=0xAABBCCDD held stable until mack. dready=1 with drdata=0.
- Collision and starvation: ireq and dreq continuously high, mack immediate, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I. ireq is never starved more than 4 grants.
- Timeout: dreq=1, mack never asserted, TIMEOUT=8 -> dready with drdata=0xDEADBEEF on the 8th BUSY cycle. err=1 and stays 1. The next access then completes normally.
- Reset mid-access: reset=0 on the second BUSY_D cycle -> the next cycle shows mreq=0, dready=0, state IDLE, err=0. A late mack is ignored and no ready pulse appears.
- Back-to-back fetches: ireq held across iready -> the second access issues after exactly one IDLE bubble, with the new iaddr sampled in IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins collisions; a streak counter guarantees fetch progress, a watchdog aborts hung accesses.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic [31:0] irdata,
  output logic        iready,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [3:0]  dbe,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        dready,
  output logic        mreq,
  output logic        mwe,
  output logic [3:0]  mbe,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  input  logic [31:0] mrdata,
  input  logic        mack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam int             SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [7:0]     TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0]    ABORT_DATA = 32'hDEADBEEF;

  state_e        state_q, state_d;
  logic          mreq_q, mreq_d;
  logic          mwe_q, mwe_d;
  logic [3:0]    mbe_q, mbe_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [31:0]   mwdata_q, mwdata_d;
  logic          err_q, err_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [7:0]    timer_q, timer_d;

  logic busy, ack_v, abort, done, data_win;

  assign busy     = (state_q != IDLE);
  assign ack_v    = busy & mreq_q & mack;
  assign abort    = busy & ~ack_v & (timer_q == TIMER_LAST);
  assign done     = reset & (ack_v | abort);
  // Fetch overrides a pending data request only once data has won MAX_D_STREAK times in a row.
  assign data_win = dreq & ~(ireq & (streak_q == STREAK_MAX));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    mbe_d    = mbe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    err_d    = err_q;
    streak_d = streak_q;
    timer_d  = timer_q;
    case (state_q)
      IDLE: begin
        if (data_win) begin
          state_d  = BUSY_D;
          mreq_d   = 1'b1;
          mwe_d    = dwe;
          mbe_d    = dbe;
          maddr_d  = daddr;
          mwdata_d = dwdata;
          timer_d  = '0;
          if (!ireq)                        streak_d = '0;
          else if (streak_q != STREAK_MAX)  streak_d = streak_q + SW'(1);
        end else if (ireq) begin
          state_d  = BUSY_I;
          mreq_d   = 1'b1;
          mwe_d    = 1'b0;
          mbe_d    = 4'hF;
          maddr_d  = iaddr;
          mwdata_d = '0;
          timer_d  = '0;
          streak_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (ack_v || abort) begin
          state_d = IDLE;
          mreq_d  = 1'b0;
          err_d   = err_q | abort;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      state_q  <= IDLE;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      mbe_q    <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      err_q    <= 1'b0;
      streak_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      mbe_q    <= mbe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      err_q    <= err_d;
      streak_q <= streak_d;
      timer_q  <= timer_d;
    end
  end

  // Ready and read data are combinational from mack/mrdata; the memory port itself is all registers.
  assign iready    = done & (state_q == BUSY_I);
  assign dready    = done & (state_q == BUSY_D);
  assign irdata    = !iready ? '0 : (ack_v ? mrdata : ABORT_DATA);
  assign drdata    = !dready ? '0 : (abort ? ABORT_DATA : (mwe_q ? '0 : mrdata));
  assign stall_if  = ireq & ~iready;
  assign stall_mem = dreq & ~dready;

  assign mreq   = mreq_q;
  assign mwe    = mwe_q;
  assign mbe    = mbe_q;
  assign maddr  = maddr_q;
  assign mwdata = mwdata_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard queue holds expected completions, a negedge
// monitor pops and compares them, and the main sequence checks the memory port cycle by cycle.
module tb_mem_arbiter;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk, reset;
  logic        ireq, dreq, dwe;
  logic [31:0] iaddr, daddr, dwdata;
  logic [3:0]  dbe;
  logic [31:0] irdata, drdata, maddr, mwdata, mrdata;
  logic        iready, dready, mreq, mwe, mack, stall_if, stall_mem, err;
  logic [3:0]  mbe;

  logic        mack_r, mack_auto, mfix_en;
  logic [31:0] mfix;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  mem_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iready(iready),
    .dreq(dreq), .dwe(dwe), .dbe(dbe), .daddr(daddr), .dwdata(dwdata),
    .drdata(drdata), .dready(dready),
    .mreq(mreq), .mwe(mwe), .mbe(mbe), .maddr(maddr), .mwdata(mwdata),
    .mrdata(mrdata), .mack(mack),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  // Memory model: read data is a fixed word or a function of the address.
  assign mrdata = mfix_en ? mfix : (maddr ^ KEY);
  assign mack   = mack_r | (mack_auto & mreq);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (iready || dready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {iready, dready}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("ready_kind", {iready, dready}, {~e.is_d, e.is_d});
        check("ready_data", dready ? drdata : irdata, e.data);
      end
    end
  end

  initial begin
    reset = 1'b0; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; dbe = 4'h0;
    iaddr = '0; daddr = '0; dwdata = '0;
    mack_r = 1'b0; mack_auto = 1'b0; mfix_en = 1'b0; mfix = '0;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst_mreq", mreq, 0);
    check("rst_err", err, 0);
    check("rst_port", {mwe, mbe, maddr, mwdata}, 0);
    check("rst_ready", {iready, dready, irdata, drdata}, 0);
    tick(); reset = 1'b1;

    // Single fetch, mack in second BUSY cycle
    tick(); ireq = 1'b1; iaddr = 32'h0000_3000; mfix_en = 1'b1; mfix = 32'h2408_0005;
    push(1'b0, 32'h2408_0005);
    @(negedge clk);
    check("f1_stall_c1", stall_if, 1);
    check("f1_mreq_c1", mreq, 0);
    tick();
    @(negedge clk);
    check("f1_port", {mreq, mwe, mbe, maddr}, {1'b1, 1'b0, 4'hF, 32'h3000});
    check("f1_stall_c2", {stall_if, iready}, 2'b10);
    tick(); mack_r = 1'b1;
    @(negedge clk);
    check("f1_iready_c3", iready, 1);
    check("f1_stall_c3", stall_if, 0);
    tick(); mack_r = 1'b0; ireq = 1'b0; mfix_en = 1'b0;
    @(negedge clk);
    check("f1_idle", mreq, 0);

    // Store with mack in third BUSY cycle; store data held despite input change
    tick(); dreq = 1'b1; dwe = 1'b1; dbe = 4'b0011; daddr = 32'h10; dwdata = 32'hAABB_CCDD;
    push(1'b1, 32'h0);
    @(negedge clk);
    check("st_stall_c1", {stall_mem, mreq}, 2'b10);
    tick();
    @(negedge clk);
    check("st_port_b1", {mreq, mwe, mbe, maddr, mwdata}, {1'b1, 1'b1, 4'b0011, 32'h10, 32'hAABB_CCDD});
    check("st_dready_b1", dready, 0);
    tick(); dwdata = 32'h1111_1111;
    @(negedge clk);
    check("st_mwdata_b2", mwdata, 32'hAABB_CCDD);
    check("st_dready_b2", dready, 0);
    tick(); mack_r = 1'b1;
    @(negedge clk);
    check("st_dready_b3", {dready, stall_mem}, 2'b10);
    check("st_port_b3", {mwe, mbe, mwdata}, {1'b1, 4'b0011, 32'hAABB_CCDD});
    tick(); mack_r = 1'b0; dreq = 1'b0; dwe = 1'b0; dbe = 4'h0;
    @(negedge clk);
    check("st_idle", mreq, 0);

    // Collision: both requesting, immediate mack; fetch wins every fifth grant
    tick(); ireq = 1'b1; iaddr = 32'h100; dreq = 1'b1; daddr = 32'h200; mack_auto = 1'b1;
    for (int g = 0; g < 10; g++) begin
      if (g == 4 || g == 9) push(1'b0, 32'h100 ^ KEY);
      else                  push(1'b1, 32'h200 ^ KEY);
    end
    wait_drain("collision", 40);
    ireq = 1'b0; dreq = 1'b0;
    @(negedge clk);
    check("col_idle", mreq, 0);

    // Watchdog timeout on a load
    tick(); dreq = 1'b1; daddr = 32'h40; mack_auto = 1'b0;
    push(1'b1, 32'hDEAD_BEEF);
    for (int k = 1; k <= 8; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("to_dready_b%0d", k), dready, (k == 8) ? 64'd1 : 64'd0);
      check($sformatf("to_err_b%0d", k), err, 0);
    end
    tick(); dreq = 1'b0;
    @(negedge clk);
    check("to_err_set", err, 1);
    check("to_mreq_drop", mreq, 0);
    tick(); ireq = 1'b1; iaddr = 32'h80; mack_auto = 1'b1;
    push(1'b0, 32'h80 ^ KEY);
    wait_drain("after_to", 10);
    ireq = 1'b0;
    @(negedge clk);
    check("to_err_sticky", err, 1);

    // Reset in the second BUSY_D cycle, then a late mack
    tick(); dreq = 1'b1; daddr = 32'h60; mack_auto = 1'b0;
    tick();
    @(negedge clk);
    check("rm_busy", mreq, 1);
    tick(); reset = 1'b0;
    @(negedge clk);
    check("rm_dready_in_rst", {iready, dready}, 0);
    tick(); reset = 1'b1; dreq = 1'b0; mack_r = 1'b1;
    @(negedge clk);
    check("rm_after", {mreq, dready, err}, 0);
    check("rm_maddr", maddr, 0);
    tick();
    @(negedge clk);
    check("rm_late_mack", {mreq, iready, dready}, 0);
    tick(); mack_r = 1'b0;

    // Back-to-back fetches with one IDLE bubble
    tick(); ireq = 1'b1; iaddr = 32'h500; mack_auto = 1'b1;
    push(1'b0, 32'h500 ^ KEY);
    push(1'b0, 32'h504 ^ KEY);
    tick();
    @(negedge clk);
    check("bb_first", {iready, maddr}, {1'b1, 32'h500});
    tick(); iaddr = 32'h504;
    @(negedge clk);
    check("bb_bubble", {mreq, iready}, 0);
    tick();
    @(negedge clk);
    check("bb_second", {mreq, iready, maddr}, {1'b1, 1'b1, 32'h504});
    tick(); ireq = 1'b0;
    @(negedge clk);
    check("bb_idle", mreq, 0);

    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
